// File: rtl/xyrgb_entry_pkg.sv
// Shared encodings and helpers for the X/Y/RGB operator-entry stage.
package xyrgb_entry_pkg;

    localparam logic [1:0] MODE_X   = 2'd0;
    localparam logic [1:0] MODE_Y   = 2'd1;
    localparam logic [1:0] MODE_RGB = 2'd2;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    localparam logic [8:0] RGB_RESET = 9'h1FF;

    // Increment with wrap to zero once the field's largest legal value is reached.
    function automatic logic [8:0] wrap_inc(input logic [8:0] v, input logic [8:0] max_v);
        return (v >= max_v) ? 9'd0 : v + 9'd1;
    endfunction

endpackage

// File: rtl/xyrgb_entry_key_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchronizer, stability counter,
// and a one-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
    parameter logic [15:0] DEB_CYCLES = 16'd40000
) (
    input  logic clk,
    input  logic NRST,
    input  logic raw_n,
    output logic level,
    output logic press
);

    logic        sync1_q;
    logic        sync2_q;
    logic        level_q;
    logic        press_q;
    logic [15:0] cnt_q;

    // The level only moves after the synchronized input has disagreed with it
    // for DEB_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= 16'd0;
            end else if (cnt_q >= DEB_CYCLES - 16'd1) begin
                level_q <= sync2_q;
                press_q <= ~sync2_q;
                cnt_q   <= 16'd0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/xyrgb_entry.sv
// Operator entry: debounced keys select a field (X, Y, RGB) and either load it
// from the switches or step it, with auto-repeat while the apply key is held.
module xyrgb_entry
    import xyrgb_entry_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES    = 16'd40000,
    parameter logic [23:0] REPEAT_DELAY  = 24'd20000000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd4000000,
    parameter logic [7:0]  X_MAX         = 8'd199,
    parameter logic [7:0]  Y_MAX         = 8'd149
) (
    input  logic       clk,
    input  logic       NRST,
    input  logic [9:0] SW,
    input  logic [3:0] key,
    output logic [7:0] Xin,
    output logic [7:0] Yin,
    output logic [8:0] RGBin,
    output logic [1:0] mode,
    output logic       upd
);

    logic apply_level;
    logic apply_press;
    logic sel_level_unused;
    logic sel_press;
    logic unused_keys;

    assign unused_keys = key[0] ^ key[3];

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_apply_key (
        .clk   (clk),
        .NRST  (NRST),
        .raw_n (key[1]),
        .level (apply_level),
        .press (apply_press)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_select_key (
        .clk   (clk),
        .NRST  (NRST),
        .raw_n (key[2]),
        .level (sel_level_unused),
        .press (sel_press)
    );

    rpt_state_e  rpt_q, rpt_d;
    logic [23:0] rpt_cnt_q, rpt_cnt_d;
    logic [23:0] rpt_limit;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [8:0]  rgb_q, rgb_d;
    logic [1:0]  mode_q, mode_d;
    logic        upd_q, upd_d;
    logic        do_step;
    logic        do_load;

    assign rpt_limit = (rpt_q == RPT_DELAY) ? REPEAT_DELAY : REPEAT_PERIOD;

    // Repeat sequencer: decides when an apply press or a held key produces an edit.
    always_comb begin
        rpt_d     = rpt_q;
        rpt_cnt_d = rpt_cnt_q;
        do_step   = 1'b0;
        do_load   = 1'b0;
        case (rpt_q)
            RPT_IDLE: begin
                if (apply_press) begin
                    rpt_cnt_d = 24'd0;
                    if (SW[9]) begin
                        do_step = 1'b1;
                        if (!sel_press) begin
                            rpt_d = RPT_DELAY;
                        end
                    end else begin
                        do_load = 1'b1;
                    end
                end
            end
            RPT_DELAY, RPT_REPEAT: begin
                if (apply_level || !SW[9] || sel_press) begin
                    rpt_d     = RPT_IDLE;
                    rpt_cnt_d = 24'd0;
                end else if (rpt_cnt_q >= rpt_limit - 24'd1) begin
                    do_step   = 1'b1;
                    rpt_d     = RPT_REPEAT;
                    rpt_cnt_d = 24'd0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 24'd1;
                end
            end
            default: begin
                rpt_d     = RPT_IDLE;
                rpt_cnt_d = 24'd0;
            end
        endcase
    end

    // Field writes use the mode held before any same-cycle select press.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        rgb_d = rgb_q;
        if (do_load) begin
            case (mode_q)
                MODE_X:   x_d   = (SW[7:0] > X_MAX) ? X_MAX : SW[7:0];
                MODE_Y:   y_d   = (SW[7:0] > Y_MAX) ? Y_MAX : SW[7:0];
                MODE_RGB: rgb_d = SW[8:0];
                default:  ;
            endcase
        end else if (do_step) begin
            case (mode_q)
                MODE_X:   x_d   = 8'(wrap_inc({1'b0, x_q}, {1'b0, X_MAX}));
                MODE_Y:   y_d   = 8'(wrap_inc({1'b0, y_q}, {1'b0, Y_MAX}));
                MODE_RGB: rgb_d = wrap_inc(rgb_q, 9'h1FF);
                default:  ;
            endcase
        end
        upd_d = (do_load | do_step) & (mode_q <= MODE_RGB);

        if (sel_press) begin
            mode_d = (mode_q >= MODE_RGB) ? MODE_X : mode_q + 2'd1;
        end else begin
            mode_d = (mode_q > MODE_RGB) ? MODE_X : mode_q;
        end
    end

    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            rpt_q     <= RPT_IDLE;
            rpt_cnt_q <= 24'd0;
            x_q       <= 8'd0;
            y_q       <= 8'd0;
            rgb_q     <= RGB_RESET;
            mode_q    <= MODE_X;
            upd_q     <= 1'b0;
        end else begin
            rpt_q     <= rpt_d;
            rpt_cnt_q <= rpt_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rgb_q     <= rgb_d;
            mode_q    <= mode_d;
            upd_q     <= upd_d;
        end
    end

    assign Xin   = x_q;
    assign Yin   = y_q;
    assign RGBin = rgb_q;
    assign mode  = mode_q;
    assign upd   = upd_q;

endmodule

// File: tb/tb_xyrgb_entry.sv
// Directed bench for xyrgb_entry with a cycle-level behavioural model and literal pins.
module tb_xyrgb_entry;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sw    = 10'd0;
    logic [3:0] key   = 4'hF;
    logic [7:0] xin, yin;
    logic [8:0] rgb;
    logic [1:0] mode;
    logic       upd;

    always #5 clk = ~clk;

    xyrgb_entry #(
        .DEB_CYCLES   (16'd4),
        .REPEAT_DELAY (24'd20),
        .REPEAT_PERIOD(24'd5)
    ) dut (
        .clk  (clk),
        .NRST (rst_n),
        .SW   (sw),
        .key  (key),
        .Xin  (xin),
        .Yin  (yin),
        .RGBin(rgb),
        .mode (mode),
        .upd  (upd)
    );

    int vectors     = 0;
    int miscompares = 0;
    int updc        = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit rawq [2][$];
    bit synq [2][$];
    bit m_lvl [2];
    bit m_press [2];
    int mx, my, mrgb, mmode, t;
    bit mupd, armed;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            rawq[k] = {1'b1, 1'b1};
            synq[k].delete();
            m_lvl[k]   = 1'b1;
            m_press[k] = 1'b0;
        end
        mx = 0; my = 0; mrgb = 511; mmode = 0; mupd = 0; armed = 0; t = 0;
    endtask

    task automatic model_edge();
        bit p1, p2, l1, stepped, loaded, syn, all_diff;
        int v;
        p1 = m_press[0]; p2 = m_press[1]; l1 = m_lvl[0];
        stepped = 0; loaded = 0;
        if (p1) begin
            if (sw[9]) begin stepped = 1; armed = !p2; t = 0; end
            else begin loaded = 1; armed = 0; end
        end else if (armed) begin
            if (l1 || !sw[9] || p2) armed = 0;
            else begin
                t++;
                if (t == RD || (t > RD && (t - RD) % RP == 0)) stepped = 1;
            end
        end
        if (loaded) begin
            v = int'(sw[7:0]);
            if (mmode == 0) mx = (v > 199) ? 199 : v;
            else if (mmode == 1) my = (v > 149) ? 149 : v;
            else mrgb = int'(sw[8:0]);
        end
        if (stepped) begin
            if (mmode == 0) mx = (mx == 199) ? 0 : mx + 1;
            else if (mmode == 1) my = (my == 149) ? 0 : my + 1;
            else mrgb = (mrgb == 511) ? 0 : mrgb + 1;
        end
        mupd = stepped || loaded;
        if (p2) mmode = (mmode + 1) % 3;
        for (int k = 0; k < 2; k++) begin
            rawq[k].push_back(key[k+1]);
            syn = rawq[k].pop_front();
            synq[k].push_back(syn);
            if (synq[k].size() > DEB) void'(synq[k].pop_front());
            m_press[k] = 1'b0;
            if (synq[k].size() == DEB) begin
                all_diff = 1;
                for (int i = 0; i < DEB; i++) if (synq[k][i] == m_lvl[k]) all_diff = 0;
                if (all_diff) begin
                    m_lvl[k]   = !m_lvl[k];
                    m_press[k] = !m_lvl[k];
                    synq[k].delete();
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge();
        end
    end

    always @(negedge clk) begin
        chk("Xin", int'(xin), mx);
        chk("Yin", int'(yin), my);
        chk("RGBin", int'(rgb), mrgb);
        chk("mode", int'(mode), mmode);
        chk("upd", int'(upd), int'(mupd));
        if (upd === 1'b1) updc++;
    end

    // ---------------- stimulus ----------------
    task automatic tap(input int which, input int hold);
        @(negedge clk);
        key[which] = 1'b0;
        repeat (hold) @(negedge clk);
        key[which] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic tap_both(input int hold);
        @(negedge clk);
        key[2:1] = 2'b00;
        repeat (hold) @(negedge clk);
        key[2:1] = 2'b11;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int u0, lat;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: reset values, short pulse and bounce ignored
        chk("rst_X", int'(xin), 0);
        chk("rst_Y", int'(yin), 0);
        chk("rst_RGB", int'(rgb), 'h1FF);
        chk("rst_mode", int'(mode), 0);
        chk("rst_upd", int'(upd), 0);
        u0 = updc;
        tap(1, 3);
        for (int i = 0; i < 6; i++) begin
            key[1] = ~key[1];
            repeat (2) @(negedge clk);
        end
        key[1] = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_upd", updc - u0, 0);
        chk("glitch_X", int'(xin), 0);
        $display("T1 glitch rejection: X=%0d upd pulses=%0d", xin, updc - u0);

        // 2: load mode with clamp and latency
        sw = 10'h0C8;
        @(negedge clk);
        key[1] = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (upd === 1'b1 && lat < 0) lat = c;
        end
        key[1] = 1'b1;
        repeat (10) @(negedge clk);
        chk("load_latency", lat, 7);
        chk("load_X_clamp", int'(xin), 199);
        tap(2, 8);
        sw = 10'h05A;
        tap(1, 8);
        chk("load_Y", int'(yin), 90);
        tap(2, 8);
        sw = 10'h1C7;
        tap(1, 8);
        chk("load_RGB", int'(rgb), 'h1C7);
        chk("mode_RGB", int'(mode), 2);
        $display("T2 load: X=%0d Y=%0d RGB=%03h latency=%0d", xin, yin, rgb, lat);

        // 3: step wraps
        tap(2, 8);
        tap(2, 8);
        sw = 10'h095;
        tap(1, 8);
        chk("load_Y_149", int'(yin), 149);
        sw = 10'h200;
        tap(1, 8);
        chk("wrap_Y", int'(yin), 0);
        tap(2, 8);
        sw = 10'h1FF;
        tap(1, 8);
        sw = 10'h200;
        tap(1, 8);
        chk("wrap_RGB", int'(rgb), 0);
        tap(2, 8);
        tap(1, 8);
        chk("wrap_X", int'(xin), 0);
        $display("T3 wrap: X=%0d Y=%0d RGB=%0d", xin, yin, rgb);

        // 4: auto-repeat
        sw = 10'h005;
        tap(1, 8);
        sw = 10'h200;
        u0 = updc;
        tap(1, 53);
        repeat (30) @(negedge clk);
        chk("repeat_X", int'(xin), 13);
        chk("repeat_steps", updc - u0, 8);
        sw = 10'h2AA;
        repeat (20) @(negedge clk);
        chk("idle_after_release", int'(xin), 13);
        $display("T4 auto-repeat: X=%0d steps=%0d", xin, updc - u0);

        // 5: simultaneous apply and select
        sw = 10'h012;
        tap_both(8);
        chk("simul_X", int'(xin), 18);
        chk("simul_mode", int'(mode), 1);
        $display("T5 simultaneous: X=%0d mode=%0d", xin, mode);

        // 6: async reset mid auto-repeat, key held through release
        tap(2, 8);
        tap(2, 8);
        sw = 10'h200;
        @(negedge clk);
        key[1] = 1'b0;
        repeat (35) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_X", int'(xin), 0);
        chk("async_Y", int'(yin), 0);
        chk("async_RGB", int'(rgb), 'h1FF);
        chk("async_mode", int'(mode), 0);
        chk("async_upd", int'(upd), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("held_pre_step", int'(xin), 0);
        @(negedge clk);
        chk("held_first_step", int'(xin), 1);
        repeat (20) @(negedge clk);
        chk("held_delay_step", int'(xin), 2);
        repeat (5) @(negedge clk);
        chk("held_repeat_step", int'(xin), 3);
        key[1] = 1'b1;
        repeat (20) @(negedge clk);
        $display("T6 async reset: X=%0d after re-arm", xin);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
